// File: rtl/maj_bit_packer.sv
// maj_bit_packer: packs 1-bit majority results LSB first into W-bit words and
// queues them in a first-word-fall-through FIFO of DEPTH entries.
// Optional build macro MAJ_PACK_BIPOLAR_PAD_EN: pad bits of short words
// alternate 1/0 (1 at even positions) instead of all zero.
module maj_bit_packer #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         in_bit,
  input  logic         in_last,
  output logic         in_ready,
  output logic         almost_full,
  output logic         overflow,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready
);

  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IW-1:0] IdxMax   = IW'(W - 1);
  localparam logic [AW:0]   CntFull  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CntAfull = (AW + 1)'(DEPTH - 1);

  // Fill value for bit positions above the last accepted bit of a short word.
  function automatic logic [W-1:0] pad_pattern();
    logic [W-1:0] p;
    p = '0;
`ifdef MAJ_PACK_BIPOLAR_PAD_EN
    for (int i = 0; i < int'(W); i++) begin
      p[i] = ((i % 2) == 0);
    end
`endif
    return p;
  endfunction

  localparam logic [W-1:0] PadBits = pad_pattern();

  // Packing state
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  pk_q, pk_d;
  logic          overflow_q, overflow_d;

  // FIFO state
  logic [W-1:0]  mem_q      [DEPTH];
  logic          last_mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  logic          accept;
  logic          complete;
  logic          push;
  logic          pop;
  logic [W-1:0]  word;

  // Handshake status comes from the registered count only
  always_comb begin
    in_ready    = (count_q != CntFull);
    almost_full = (count_q >= CntAfull);
    out_valid   = (count_q != '0);
    overflow    = overflow_q;
    out_data    = out_valid ? mem_q[rptr_q] : '0;
    out_last    = out_valid ? last_mem_q[rptr_q] : 1'b0;
    accept      = in_valid && in_ready;
    complete    = accept && (in_last || (idx_q == IdxMax));
    push        = complete;
    pop         = out_valid && out_ready;
  end

  // Assemble the word being closed: held bits below idx, new bit at idx, pad above
  always_comb begin
    word = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (i < int'(idx_q)) begin
        word[i] = pk_q[i];
      end else if (i == int'(idx_q)) begin
        word[i] = in_bit;
      end else begin
        word[i] = PadBits[i];
      end
    end
  end

  // Next state for the pack register, index and sticky overflow
  always_comb begin
    idx_d      = idx_q;
    pk_d       = pk_q;
    overflow_d = overflow_q;
    if (in_valid && !in_ready) begin
      overflow_d = 1'b1;
    end
    if (complete) begin
      idx_d = '0;
      pk_d  = '0;
    end else if (accept) begin
      idx_d        = idx_q + IW'(1);
      pk_d[idx_q]  = in_bit;
    end
  end

  // Next state for FIFO pointers and occupancy
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= '0;
      pk_q       <= '0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      idx_q      <= idx_d;
      pk_q       <= pk_d;
      overflow_q <= overflow_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are invalidated by the pointer reset, not cleared
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q]      <= word;
      last_mem_q[wptr_q] <= in_last;
    end
  end

endmodule

// File: tb/tb_maj_bit_packer.sv
// Self-checking bench for maj_bit_packer: scoreboard queue of expected words,
// directed scenarios followed by a random run with a 2-cycle launch pipeline.
module tb_maj_bit_packer;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_bit;
  logic         in_last;
  logic         in_ready;
  logic         almost_full;
  logic         overflow;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready;

  maj_bit_packer #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .almost_full (almost_full),
    .overflow    (overflow),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W:0]   sb [$];  // {last, data}
  int           m_idx;
  logic [W-1:0] m_pk;
  logic         m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic pad_bit(input int i);
`ifdef MAJ_PACK_BIPOLAR_PAD_EN
    return ((i % 2) == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_clear();
    sb.delete();
    m_idx = 0;
    m_pk  = '0;
    m_ovf = 1'b0;
  endfunction

  // Drive one beat at a negedge, compare DUT state with the model, advance the model.
  task automatic step(input logic v, input logic b, input logic l, input logic r);
    int           sz;
    logic         acc;
    logic [W-1:0] w;
    in_valid  = v;
    in_bit    = b;
    in_last   = l;
    out_ready = r;
    sz = sb.size();
    check("in_ready", 64'(in_ready), 64'(sz != int'(DEPTH)));
    check("almost_full", 64'(almost_full), 64'(sz >= int'(DEPTH) - 1));
    check("out_valid", 64'(out_valid), 64'(sz != 0));
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (sz != 0) begin
      check("out_data", 64'(out_data), 64'(sb[0][W-1:0]));
      check("out_last", 64'(out_last), 64'(sb[0][W]));
    end else begin
      check("idle_data", 64'(out_data), 64'(0));
      check("idle_last", 64'(out_last), 64'(0));
    end
    acc = v && (sz != int'(DEPTH));
    if (v && !acc) m_ovf = 1'b1;
    if (sz != 0 && r) void'(sb.pop_front());
    if (acc) begin
      w        = m_pk;
      w[m_idx] = b;
      if (l || m_idx == int'(W) - 1) begin
        for (int i = m_idx + 1; i < int'(W); i++) w[i] = pad_bit(i);
        sb.push_back({l, w});
        m_idx = 0;
        m_pk  = '0;
      end else begin
        m_pk  = w;
        m_idx = m_idx + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] val, input logic r);
    for (int i = 0; i < int'(W); i++) step(1'b1, val[i], 1'b0, r);
  endtask

  task automatic pulse_reset(input int cycles);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < cycles; i++) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_almost_full", 64'(almost_full), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
  endtask

  logic [1:0]   launch_pipe;
  logic         launch;
  logic         v;
  logic         l;
  logic [W-1:0] exp_short;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    model_clear();
    @(negedge clk);
    pulse_reset(2);
    check_reset_outputs();

    // 1,0,1,1 then 12 zeros -> 0x000D, single-cycle out_valid
    send_word(16'h000D, 1'b1);
    check("word1_valid", 64'(out_valid), 64'(1));
    check("word1_data", 64'(out_data), 64'h000D);
    check("word1_last", 64'(out_last), 64'(0));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("word1_pulse", 64'(out_valid), 64'(0));

    // Five-bit frame of ones closed by in_last
`ifdef MAJ_PACK_BIPOLAR_PAD_EN
    exp_short = 16'h555F;
`else
    exp_short = 16'h001F;
`endif
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, (i == 4), 1'b1);
    check("short_data", 64'(out_data), 64'(exp_short));
    check("short_last", 64'(out_last), 64'(1));
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Fill the FIFO with out_ready held low
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    check("af_after2", 64'(almost_full), 64'(0));
    send_word(16'h3333, 1'b0);
    check("af_after3", 64'(almost_full), 64'(1));
    check("rdy_after3", 64'(in_ready), 64'(1));
    send_word(16'h4444, 1'b0);
    check("rdy_after4", 64'(in_ready), 64'(0));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("ovf_set", 64'(overflow), 64'(1));
    check("full_head", 64'(out_data), 64'h1111);

    // Pop while in_valid stays high: bit dropped, in_ready opens next cycle
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("drain_rdy", 64'(in_ready), 64'(1));
    check("drain_ovf", 64'(overflow), 64'(1));
    check("drain_head", 64'(out_data), 64'h2222);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame with idx = 7 and 2 words queued
    send_word(16'h5A5A, 1'b0);
    send_word(16'hA5A5, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    pulse_reset(1);
    check_reset_outputs();
    send_word(16'h8001, 1'b1);
    check("clean_valid", 64'(out_valid), 64'(1));
    check("clean_data", 64'(out_data), 64'h8001);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic; launcher honours almost_full with 2 bits in flight
    launch_pipe = 2'b00;
    for (int c = 0; c < 10000; c++) begin
      launch      = ($urandom_range(0, 3) != 0) && !(sb.size() >= int'(DEPTH) - 1);
      v           = launch_pipe[1];
      launch_pipe = {launch_pipe[0], launch};
      l           = v && (m_idx >= 3) && ($urandom_range(0, 7) == 0);
      step(v, 1'($urandom_range(0, 1)), l, 1'($urandom_range(0, 1)));
    end
    for (int c = 0; c < 2; c++) begin
      v           = launch_pipe[1];
      launch_pipe = {launch_pipe[0], 1'b0};
      step(v, 1'b0, 1'b0, 1'b1);
    end
    for (int c = 0; c < int'(DEPTH) + 2; c++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("rand_no_ovf", 64'(overflow), 64'(0));
    check("rand_drained", 64'(out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maj_bit_packer.md
# maj_bit_packer

Downstream stage of the registered single-majority unit. It collects the 1-bit majority results of one neuron row, LSB first, into W-bit activation words and buffers them in a small first-word-fall-through FIFO for the next layer's operand fetch. Because the majority stage has no backpressure, the block also gives the upstream launcher an early stall hint (`almost_full`) and flags any dropped bits with a sticky overflow.

## Interface
- `W`, 16: output word width in bits; W ≥ 2.
- `DEPTH`, 4: FIFO depth in words; power of two, ≥ 2.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: a majority bit is present. Aligned by the upstream scheduler with the majority stage's 2-cycle latency.
- `in_bit` input 1: the majority result.
- `in_last` input 1: last bit of the frame; qualified by `in_valid`.
- `in_ready` output 1: equal to `!fifo_full`.
- `almost_full` output 1: FIFO occupancy ≥ DEPTH-1; used by the launcher as a stall hint.
- `overflow` output 1: sticky. Set when `in_valid && !in_ready`; cleared only by reset.
- `out_valid` output 1: FIFO not empty.
- `out_data` output W: FIFO head word; forced to 0 while `out_valid` = 0.
- `out_last` output 1: head word closes a frame; 0 while `out_valid` = 0.
- `out_ready` input 1: consumer accepts the head word.

## Operation
- An input bit is accepted when `in_valid && in_ready`. Otherwise `in_bit` and `in_last` are ignored.
- A dropped bit (`in_valid && !in_ready`) sets `overflow`. The packing state is unchanged.
- The pack index `idx` (0..W-1) and the pack register `pk[W-1:0]` hold the partial word. An accepted bit is written to `pk[idx]`.
- Word completion happens on an accepted bit with `idx == W-1` or `in_last == 1`:
  - The completed word (current `pk` with the new bit at `idx`, pad bits above `idx`) is pushed with last flag = `in_last`.
  - `idx` returns to 0 and `pk` clears to 0.
- Other accepted bits increment `idx`.
- `in_last` with `idx == W-1` produces a full word with no padding and last = 1.
- FIFO behaviour:
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, no push is possible. `in_ready` is derived from the registered count only, so a same-cycle pop does not open `in_ready`.
  - Read and write pointers wrap modulo DEPTH. An extra count bit distinguishes full from empty.
- Reset values: `idx` = 0, `pk` = 0, FIFO count = 0, `overflow` = 0, `in_ready` = 1, `almost_full` = 0, `out_valid` = 0, `out_data` = 0, `out_last` = 0.
- Reset asserted mid-frame discards the partial word and all FIFO contents.

## Timing
- Latency from the accepted word-completing bit to `out_valid` is 1 cycle when the FIFO is empty. `out_data` is valid in that same cycle.
- Throughput is one input bit per cycle and one output word per cycle.
- `in_ready` deasserts the cycle after the push that fills the FIFO.
- `almost_full` rises the cycle after occupancy reaches DEPTH-1. The launcher must stop issuing majority operands while it is high; this covers the 2 bits in flight in the majority stage.
- `overflow` rises the cycle after the dropping beat.

## Configuration
- `MAJ_PACK_BIPOLAR_PAD_EN` defined: pad bit at position i is 1 for even i and 0 for odd i. Padding therefore stays balanced under ±1 interpretation downstream.
- Not defined: all pad bits are 0.
- Full words are identical in both builds.

## Test plan
- Reset, then W=16: stream bits 1,0,1,1 followed by 12 zeros, `out_ready` = 1 → one cycle after the 16th bit, `out_data` = 0x000D, `out_last` = 0, `out_valid` pulses 1 cycle.
- Frame of 5 bits, all 1, with `in_last` on the 5th bit → `out_data` = 0x001F and `out_last` = 1. With `MAJ_PACK_BIPOLAR_PAD_EN`, the expected value is 0x555F.
- Hold `out_ready` = 0, DEPTH=4, push 4 full words → `almost_full` rises after word 3 and `in_ready` = 0 after word 4. A further `in_valid` beat sets `overflow` = 1; the FIFO keeps 4 words in order.
- Drain the full FIFO by raising `out_ready` while `in_valid` stays high → no bit is accepted in the pop cycle, `in_ready` returns to 1 the next cycle, and `overflow` remains 1.
- Assert `rst_n` = 0 for 1 cycle with idx = 7 and 2 words queued → all outputs return to their reset values. The next 16 bits form a clean word starting at bit 0.
- Random `in_valid`/`out_ready` over 10k cycles against a reference model → the word sequence and `out_last` flags match, and `overflow` stays 0 whenever the launcher honours `almost_full`.
